// File: rtl/ov7670_pkg.sv
// OV7670 capture shared definitions: FSM states,
// error bit indices and the QQVGA frame geometry.
package ov7670_pkg;

  localparam int QQVGA_H = 160;
  localparam int QQVGA_V = 120;

  localparam int ERR_ODD   = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_FRAME = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACTIVE
  } cap_state_e;

endpackage

// File: rtl/ov7670_in_sync.sv
// Oversampling synchronizer and edge detector for the DVP inputs.
// Ports: cam_* in; pclk_rise/href_fall/vs_rise/vs_fall, href_s2, d_s2 out.
module ov7670_in_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_d,
  output logic       pclk_rise,
  output logic       href_fall,
  output logic       vs_rise,
  output logic       vs_fall,
  output logic       href_s2,
  output logic [7:0] d_s2
);

  // [0]=s1, [1]=s2, [2]=s3
  logic [2:0] pclk_sr;
  logic [2:0] vs_sr;
  logic [2:0] href_sr;
  logic [7:0] d_s1;
  logic [7:0] d_s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pclk_sr <= '0;
      vs_sr   <= '0;
      href_sr <= '0;
      d_s1    <= '0;
      d_s2_q  <= '0;
    end else begin
      pclk_sr <= {pclk_sr[1:0], cam_pclk};
      vs_sr   <= {vs_sr[1:0], cam_vsync};
      href_sr <= {href_sr[1:0], cam_href};
      d_s1    <= cam_d;
      d_s2_q  <= d_s1;
    end
  end

  assign pclk_rise = pclk_sr[1] & ~pclk_sr[2];
  assign href_fall = ~href_sr[1] & href_sr[2];
  assign vs_rise   = vs_sr[1] & ~vs_sr[2];
  assign vs_fall   = ~vs_sr[1] & vs_sr[2];
  assign href_s2   = href_sr[1];
  assign d_s2      = d_s2_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 DVP capture: frame lock, RGB565 packing, linear write port.
// Ports: cfg_done/capture_en/cam_*/err_clr in; pix_*/frame_*/busy/err_flags out.
import ov7670_pkg::*;

module ov7670_capture #(
  parameter int H_ACTIVE = QQVGA_H,
  parameter int V_ACTIVE = QQVGA_V,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_done,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  input  logic              err_clr,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_we,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic [2:0]        err_flags
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] H_LIM = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_LIM = YW'(V_ACTIVE);

  logic       pclk_rise;
  logic       href_fall;
  logic       vs_rise;
  logic       vs_fall;
  logic       href_s2;
  logic [7:0] d_s2;

  ov7670_in_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .cam_pclk  (cam_pclk),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_d     (cam_d),
    .pclk_rise (pclk_rise),
    .href_fall (href_fall),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .href_s2   (href_s2),
    .d_s2      (d_s2)
  );

  // Registered event stage between the edge detector and the FSM
  logic       ev_byte;
  logic       ev_hfall;
  logic       ev_vrise;
  logic       ev_vfall;
  logic [7:0] ev_d;

  cap_state_e        state;
  cap_state_e        state_d;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              phase;
  logic [7:0]        hi;
  logic [ADDR_W-1:0] addr;

  logic       wr;
  logic       done;
  logic       start_frm;
  logic       line_end;
  logic       take_hi;
  logic       take_lo;
  logic [2:0] err_set;

  always_comb begin
    state_d   = state;
    wr        = 1'b0;
    done      = 1'b0;
    start_frm = 1'b0;
    line_end  = 1'b0;
    take_hi   = 1'b0;
    take_lo   = 1'b0;
    err_set   = '0;
    unique case (state)
      S_IDLE: begin
        if (cfg_done && capture_en) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!capture_en) begin
          state_d = S_IDLE;
        end else if (ev_vfall) begin
          state_d   = S_ACTIVE;
          start_frm = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (ev_vrise) begin
          done = 1'b1;
          if (y != V_LIM) err_set[ERR_FRAME] = 1'b1;
          state_d = capture_en ? S_ARMED : S_IDLE;
        end else if (ev_hfall) begin
          line_end = 1'b1;
          if (phase) err_set[ERR_ODD] = 1'b1;
        end else if (ev_byte) begin
          if (!phase) begin
            take_hi = 1'b1;
          end else begin
            take_lo = 1'b1;
            if (x < H_LIM && y < V_LIM) begin
              wr = 1'b1;
            end else begin
              if (x >= H_LIM) err_set[ERR_LONG] = 1'b1;
              if (y >= V_LIM) err_set[ERR_FRAME] = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Losing configuration aborts silently from any busy state
    if (!cfg_done && state != S_IDLE) begin
      state_d   = S_IDLE;
      wr        = 1'b0;
      done      = 1'b0;
      start_frm = 1'b0;
      line_end  = 1'b0;
      take_hi   = 1'b0;
      take_lo   = 1'b0;
      err_set   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev_byte     <= 1'b0;
      ev_hfall    <= 1'b0;
      ev_vrise    <= 1'b0;
      ev_vfall    <= 1'b0;
      ev_d        <= '0;
      state       <= S_IDLE;
      x           <= '0;
      y           <= '0;
      phase       <= 1'b0;
      hi          <= '0;
      addr        <= '0;
      pix_data    <= '0;
      pix_addr    <= '0;
      pix_we      <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_flags   <= '0;
    end else begin
      ev_byte     <= pclk_rise & href_s2;
      ev_hfall    <= href_fall;
      ev_vrise    <= vs_rise;
      ev_vfall    <= vs_fall;
      ev_d        <= d_s2;
      state       <= state_d;
      pix_we      <= wr;
      frame_start <= wr && x == '0 && y == '0;
      frame_done  <= done;
      // A new error in the clearing cycle survives
      err_flags   <= (err_flags & ~{3{err_clr}}) | err_set;
      if (start_frm) begin
        x     <= '0;
        y     <= '0;
        phase <= 1'b0;
        addr  <= '0;
      end
      if (take_hi) begin
        hi    <= ev_d;
        phase <= 1'b1;
      end
      if (take_lo) phase <= 1'b0;
      if (wr) begin
        pix_data <= {hi, ev_d};
        pix_addr <= addr;
        addr     <= addr + ADDR_W'(1);
        x        <= x + XW'(1);
      end
      if (line_end) begin
        phase <= 1'b0;
        x     <= '0;
        if (y != V_LIM) y <= y + YW'(1);
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture with a reduced frame size
// and a frame-level reference model of expected writes and errors.
module tb_ov7670_capture;

  localparam int H  = 16;
  localparam int V  = 12;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_done;
  logic          capture_en;
  logic          cam_pclk;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_d;
  logic          err_clr;
  logic [15:0]   pix_data;
  logic [AW-1:0] pix_addr;
  logic          pix_we;
  logic          frame_start;
  logic          frame_done;
  logic          busy;
  logic [2:0]    err_flags;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_done    (cfg_done),
    .capture_en  (capture_en),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_d       (cam_d),
    .err_clr     (err_clr),
    .pix_data    (pix_data),
    .pix_addr    (pix_addr),
    .pix_we      (pix_we),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .err_flags   (err_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] act_addr[$];
  logic [31:0] act_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int fs_cnt = 0;
  int fd_cnt = 0;
  int fs_bad = 0;
  logic [2:0] exp_err;
  bit model_on;

  always @(negedge clk) begin
    if (pix_we) begin
      act_addr.push_back(32'(pix_addr));
      act_data.push_back(32'(pix_data));
    end
    if (frame_start) begin
      fs_cnt++;
      if (!(pix_we && pix_addr == '0)) fs_bad++;
    end
    if (frame_done) fd_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_d    = b;
    cam_pclk = 1'b0;
    tick(4);
    cam_pclk = 1'b1;
    tick(4);
  endtask

  task automatic drive_line(input int l, input int nb, input bit pat);
    logic [7:0] b;
    logic [7:0] h;
    h = '0;
    cam_href = 1'b1;
    for (int k = 0; k < nb; k++) begin
      if (pat) b = (k % 2 == 0) ? 8'hA5 : 8'h3C;
      else b = 8'($urandom);
      if (k % 2 == 0) begin
        h = b;
      end else if (model_on && l < V && k / 2 < H) begin
        exp_addr.push_back(32'(l * H + k / 2));
        exp_data.push_back({16'h0, h, b});
      end
      send_byte(b);
    end
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    tick(10);
    if (model_on) begin
      if (nb % 2 == 1) exp_err[0] = 1'b1;
      if (nb / 2 > H) exp_err[1] = 1'b1;
      if (l >= V && nb >= 2) exp_err[2] = 1'b1;
    end
  endtask

  task automatic drive_frame(input int nl, input bit pat, input bit bad,
                             input int drop_line);
    int nb;
    cam_vsync = 1'b1;
    tick(16);
    cam_vsync = 1'b0;
    tick(16);
    for (int l = 0; l < nl; l++) begin
      if (l == drop_line) capture_en = 1'b0;
      nb = 2 * H;
      if (bad && l == 5) nb = 2 * H + 1;
      if (bad && l == 6) nb = 2 * (H + 10);
      drive_line(l, nb, pat);
    end
    tick(4);
    cam_vsync = 1'b1;
    tick(12);
    if (model_on && nl != V) exp_err[2] = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int base,
                             input int fs0, input int fd0);
    int n;
    n = act_addr.size() - base;
    chk({tag, "_count"}, 32'(n), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < n; i++) begin
      chk({tag, "_addr"}, act_addr[base + i], exp_addr[i]);
      chk({tag, "_data"}, act_data[base + i], exp_data[i]);
    end
    chk({tag, "_fstart"}, 32'(fs_cnt - fs0), 32'd1);
    chk({tag, "_fdone"}, 32'(fd_cnt - fd0), 32'd1);
    chk({tag, "_err"}, 32'(err_flags), 32'(exp_err));
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    exp_err = '0;
  endtask

  int base;
  int fs0;
  int fd0;
  int n0;

  initial begin
    rst_n      = 1'b0;
    cfg_done   = 1'b1;
    capture_en = 1'b1;
    cam_pclk   = 1'b0;
    cam_vsync  = 1'b0;
    cam_href   = 1'b0;
    cam_d      = '0;
    err_clr    = 1'b0;
    exp_err    = '0;
    model_on   = 1'b0;

    tick(5);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_addr", 32'(pix_addr), 32'd0);
    chk("rst_we", 32'(pix_we), 32'd0);
    chk("rst_fstart", 32'(frame_start), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_flags), 32'd0);
    rst_n = 1'b1;
    tick(4);

    drive_line(0, 2 * H, 1'b0);
    drive_line(1, 2 * H, 1'b0);
    chk("armed_nowrite", 32'(act_addr.size()), 32'd0);
    chk("armed_busy", 32'(busy), 32'd1);

    model_on = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    base = act_addr.size();
    fs0 = fs_cnt;
    fd0 = fd_cnt;
    drive_frame(V, 1'b1, 1'b0, -1);
    check_frame("full", base, fs0, fd0);
    chk("full_fsbad", 32'(fs_bad), 32'd0);

    fd0 = fd_cnt;
    cam_vsync = 1'b1;
    tick(16);
    cam_vsync = 1'b0;
    tick(16);
    cam_href = 1'b1;
    send_byte(8'h12);
    cam_d    = 8'h34;
    cam_pclk = 1'b0;
    tick(4);
    cam_pclk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("lat_early", 32'(pix_we), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_we", 32'(pix_we), 32'd1);
    chk("lat_data", 32'(pix_data), 32'h1234);
    chk("lat_addr", 32'(pix_addr), 32'd0);
    chk("lat_fstart", 32'(frame_start), 32'd1);
    tick(4);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    tick(10);
    cam_vsync = 1'b1;
    tick(12);
    chk("lat_fdone", 32'(fd_cnt - fd0), 32'd1);
    chk("lat_err", 32'(err_flags), 32'd4);
    pulse_clr();
    chk("lat_clr", 32'(err_flags), 32'd0);

    exp_addr.delete();
    exp_data.delete();
    base = act_addr.size();
    fs0 = fs_cnt;
    fd0 = fd_cnt;
    drive_frame(V, 1'b0, 1'b1, -1);
    check_frame("bad", base, fs0, fd0);
    chk("bad_err", 32'(err_flags), 32'd3);
    if (act_addr.size() > base + 7 * H)
      chk("bad_line7", act_addr[base + 7 * H], 32'(7 * H));
    else
      chk("bad_line7_present", 32'(act_addr.size() - base), 32'(V * H));
    pulse_clr();
    chk("bad_clr", 32'(err_flags), 32'd0);

    exp_addr.delete();
    exp_data.delete();
    base = act_addr.size();
    fs0 = fs_cnt;
    fd0 = fd_cnt;
    drive_frame(V / 2, 1'b0, 1'b0, -1);
    check_frame("short", base, fs0, fd0);
    chk("short_err2", 32'(err_flags[2]), 32'd1);
    pulse_clr();

    model_on = 1'b0;
    fd0 = fd_cnt;
    cam_vsync = 1'b1;
    tick(16);
    cam_vsync = 1'b0;
    tick(16);
    cam_href = 1'b1;
    for (int k = 0; k < 10; k++) send_byte(8'($urandom));
    cfg_done = 1'b0;
    tick(1);
    chk("abort_busy", 32'(busy), 32'd0);
    n0 = act_addr.size();
    for (int k = 10; k < 2 * H; k++) send_byte(8'($urandom));
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    tick(10);
    drive_line(1, 2 * H, 1'b0);
    tick(4);
    cam_vsync = 1'b1;
    tick(12);
    chk("abort_nowrite", 32'(act_addr.size() - n0), 32'd0);
    chk("abort_nofdone", 32'(fd_cnt - fd0), 32'd0);
    cfg_done = 1'b1;
    tick(4);

    model_on = 1'b1;
    n0 = act_addr.size();
    fd0 = fd_cnt;
    for (int f = 0; f < 3; f++) begin
      exp_addr.delete();
      exp_data.delete();
      base = act_addr.size();
      fs0 = fs_cnt;
      drive_frame(V, 1'b0, 1'b0, -1);
      check_frame("rearm", base, fs0, fd_cnt - 1);
    end
    chk("rearm_fdone3", 32'(fd_cnt - fd0), 32'd3);
    chk("rearm_writes", 32'(act_addr.size() - n0), 32'(3 * H * V));

    exp_addr.delete();
    exp_data.delete();
    base = act_addr.size();
    fs0 = fs_cnt;
    fd0 = fd_cnt;
    drive_frame(V, 1'b0, 1'b0, -1);
    check_frame("drop_f1", base, fs0, fd0);
    exp_addr.delete();
    exp_data.delete();
    base = act_addr.size();
    fs0 = fs_cnt;
    fd0 = fd_cnt;
    drive_frame(V, 1'b0, 1'b0, V / 2);
    check_frame("drop_f2", base, fs0, fd0);
    chk("drop_idle", 32'(busy), 32'd0);
    model_on = 1'b0;
    n0 = act_addr.size();
    fd0 = fd_cnt;
    drive_frame(V, 1'b0, 1'b0, -1);
    chk("drop_f3_nowrite", 32'(act_addr.size() - n0), 32'd0);
    chk("drop_f3_nofdone", 32'(fd_cnt - fd0), 32'd0);
    chk("final_fsbad", 32'(fs_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
